// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle wide adder: one shared 4-bit ripple carry slice walks WIDTH/4 nibbles, LSB first.
// Define RCA_SEQ_SUB_EN to add the 'sub' port (subtract by inverted B plus carry-in of 1).

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[4];
    end

endmodule

module rca_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             c_in,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [3:0]       nib_a, nib_b, nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] acc_merged;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;

    // Subtraction is folded into the operand latch so the RUN datapath never changes.
    always_comb begin
`ifdef RCA_SEQ_SUB_EN
        b_in     = sub ? ~in_2 : in_2;
        carry_in = sub ? 1'b1 : c_in;
`else
        b_in     = in_2;
        carry_in = c_in;
`endif
    end

    always_comb begin
        nib_a      = '0;
        nib_b      = '0;
        acc_merged = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a                = a_q[4*i +: 4];
                nib_b                = b_q[4*i +: 4];
                acc_merged[4*i +: 4] = nib_sum;
            end
        end
    end

    ripple_carry_adder u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry_q),
        .sum   (nib_sum),
        .c_out (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = in_1;
                    b_d     = b_in;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = acc_merged;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    // Results are published only here, so no partial nibble is ever visible.
                    sum_d   = acc_merged;
                    cout_d  = nib_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (acc_merged[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed testbench for rca_nibble_sequencer (WIDTH=16); covers the sub feature when RCA_SEQ_SUB_EN is defined.

module tb_rca_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_1 = '0;
    logic [15:0] in_2 = '0;
    logic        c_in = 1'b0;
    logic        subIn = 1'b0;
    logic        busy, done, c_out, overflow;
    logic [15:0] sum;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_nibble_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_1     (in_1),
        .in_2     (in_2),
        .c_in     (c_in),
`ifdef RCA_SEQ_SUB_EN
        .sub      (subIn),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    // Presents a request for exactly one rising edge; returns at the falling edge after it.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic s);
        @(negedge clk);
        in_1 = a; in_2 = b; c_in = cin; subIn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples on falling edges until done, with a fixed cycle budget.
    task automatic wait_done(output int cycles, output int busyCycles, output bit seen, output bit sumMoved);
        logic [15:0] s0;
        s0 = sum; cycles = 0; busyCycles = 0; seen = 1'b0; sumMoved = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busyCycles++;
                if (sum !== s0) sumMoved = 1'b1;
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        tests++; if ({sum, c_out, overflow} !== 18'h0) begin errors++; $display("[TB] FAIL reset_outputs got %h/%b/%b want 0000/0/0", sum, c_out, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        int cyc, bcyc; bit seen, moved;
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if (!seen) begin errors++; $display("[TB] FAIL basic_timeout got no done want done"); end
        tests++; if (cyc !== 4) begin errors++; $display("[TB] FAIL basic_latency got %0d want 4", cyc); end
        tests++; if (bcyc !== 4) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 4", bcyc); end
        tests++; if (moved !== 1'b0) begin errors++; $display("[TB] FAIL basic_sum_hold got %b want 0", moved); end
        tests++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL basic_sum got %h want 5555", sum); end
        tests++; if ({c_out, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags got %b%b want 00", c_out, overflow); end
        @(negedge clk);
        tests++; if ({done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy); end
        tests++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL basic_sum_held got %h want 5555", sum); end
    endtask

    task automatic test_carry_chain();
        int cyc, bcyc; bit seen, moved;
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h0000, 2'b10}) begin errors++; $display("[TB] FAIL carry_ffff_1 got seen=%b %h/%b/%b want 1 0000/1/0", seen, sum, c_out, overflow); end
        launch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h0000, 2'b10}) begin errors++; $display("[TB] FAIL carry_cin got seen=%b %h/%b/%b want 1 0000/1/0", seen, sum, c_out, overflow); end
    endtask

    task automatic test_overflow();
        int cyc, bcyc; bit seen, moved;
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h8000, 2'b01}) begin errors++; $display("[TB] FAIL ovf_pos got seen=%b %h/%b/%b want 1 8000/0/1", seen, sum, c_out, overflow); end
        launch(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h0000, 2'b11}) begin errors++; $display("[TB] FAIL ovf_neg got seen=%b %h/%b/%b want 1 0000/1/1", seen, sum, c_out, overflow); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc; bit seen, moved;
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        in_1 = 16'h00FF; in_2 = 16'h0001; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_1 = 16'hDEAD; in_2 = 16'hBEEF;
        wait_done(cyc, bcyc, seen, moved);
        tests++; if (cyc !== 2) begin errors++; $display("[TB] FAIL busy_ignore_latency got %0d want 2", cyc); end
        tests++; if ({seen, sum} !== {1'b1, 16'h0002}) begin errors++; $display("[TB] FAIL busy_ignore_sum got seen=%b %h want 1 0002", seen, sum); end
        in_1 = 16'h00FF; in_2 = 16'h0001; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if ({done, busy} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_accept got done=%b busy=%b want 0 1", done, busy); end
        wait_done(cyc, bcyc, seen, moved);
        tests++; if (cyc !== 4) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 4", cyc); end
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h0100, 2'b00}) begin errors++; $display("[TB] FAIL b2b_sum got seen=%b %h/%b/%b want 1 0100/0/0", seen, sum, c_out, overflow); end
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc; bit seen, moved; bit sawDone;
        launch(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if ({busy, done, sum, c_out, overflow} !== 20'h0) begin errors++; $display("[TB] FAIL midreset_outputs got busy=%b done=%b %h/%b/%b want all 0", busy, done, sum, c_out, overflow); end
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        tests++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got %b want 0", sawDone); end
        rst_n = 1'b1;
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, cyc, sum} !== {1'b1, 32'd4, 16'h0007}) begin errors++; $display("[TB] FAIL midreset_recover got seen=%b cyc=%0d %h want 1 4 0007", seen, cyc, sum); end
    endtask

`ifdef RCA_SEQ_SUB_EN
    task automatic test_sub();
        int cyc, bcyc; bit seen, moved;
        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'hFFFE, 2'b00}) begin errors++; $display("[TB] FAIL sub_borrow got seen=%b %h/%b/%b want 1 FFFE/0/0", seen, sum, c_out, overflow); end
        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum, c_out, overflow} !== {1'b1, 16'h7FFF, 2'b11}) begin errors++; $display("[TB] FAIL sub_ovf got seen=%b %h/%b/%b want 1 7FFF/1/1", seen, sum, c_out, overflow); end
        launch(16'h0005, 16'h0007, 1'b0, 1'b0);
        wait_done(cyc, bcyc, seen, moved);
        tests++; if ({seen, sum} !== {1'b1, 16'h000C}) begin errors++; $display("[TB] FAIL sub_off_add got seen=%b %h want 1 000C", seen, sum); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef RCA_SEQ_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
